// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: lights one LED per difficulty tick, scores hits and misses, and raises the difficulty.
// Hit/miss strobes and all state are registered; outputs update one cycle after the qualifying input.
module mole_scheduler #(
  parameter int unsigned ON_CYCLES      = 100000000,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_MISSES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic [7:0] buttons,
  output logic       freq_enable,
  output logic [2:0] difficulty,
  output logic [7:0] leds,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int CNT_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam int LVL_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_LAST   = LVL_W'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]       MISS_LIMIT = 2'(MAX_MISSES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    LIT       = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       buttons_q;
  logic [2:0]       prev_idx_q, prev_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [7:0]       leds_q, leds_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       misses_q, misses_d;
  logic [2:0]       diff_q, diff_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  logic [7:0] press;
  logic [2:0] cand;
  logic [2:0] idx;
  logic       hit;
  logic [1:0] misses_inc;

  assign press      = buttons & ~buttons_q;
  assign cand       = lfsr_q[2:0];
  // Never repeat the previous target so every tick is visibly a new mole.
  assign idx        = (cand == prev_idx_q) ? cand + 3'd1 : cand;
  assign hit        = |(press & leds_q);
  assign misses_inc = misses_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    prev_idx_d = prev_idx_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    leds_d     = leds_q;
    score_d    = score_q;
    misses_d   = misses_q;
    diff_d     = diff_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          score_d  = 8'd0;
          misses_d = 2'd0;
          diff_d   = 3'd0;
          lvl_d    = '0;
          leds_d   = 8'd0;
          state_d  = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          leds_d     = 8'(1) << idx;
          prev_idx_d = idx;
          cnt_d      = CNT_LOAD;
          state_d    = LIT;
        end
      end
      LIT: begin
        // A correct press outranks the timeout in the same cycle.
        if (hit) begin
          hit_d   = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          leds_d  = 8'd0;
          state_d = WAIT_TICK;
          if (lvl_q == LVL_LAST) begin
            lvl_d  = '0;
            diff_d = (diff_q == 3'd7) ? diff_q : diff_q + 3'd1;
          end else begin
            lvl_d = lvl_q + 1'b1;
          end
        end else if (cnt_q == '0) begin
          miss_d   = 1'b1;
          misses_d = misses_inc;
          leds_d   = 8'd0;
          state_d  = (misses_inc == MISS_LIMIT) ? GAME_OVER : WAIT_TICK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= 16'hACE1;
      buttons_q  <= 8'd0;
      prev_idx_q <= 3'd0;
      cnt_q      <= '0;
      lvl_q      <= '0;
      leds_q     <= 8'd0;
      score_q    <= 8'd0;
      misses_q   <= 2'd0;
      diff_q     <= 3'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      buttons_q  <= buttons;
      prev_idx_q <= prev_idx_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      leds_q     <= leds_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      diff_q     <= diff_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign freq_enable = (state_q == WAIT_TICK) || (state_q == LIT);
  assign game_over   = (state_q == GAME_OVER);
  assign difficulty  = diff_q;
  assign leds        = leds_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a 20-cycle lit window.
module tb_mole_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic       tick;
  logic [7:0] buttons;
  logic       freq_enable;
  logic [2:0] difficulty;
  logic [7:0] leds;
  logic [7:0] score;
  logic [1:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  logic [7:0] lit;
  logic [7:0] prev_led;

  mole_scheduler #(
    .ON_CYCLES(20),
    .HITS_PER_LEVEL(4),
    .MAX_MISSES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tick(tick),
    .buttons(buttons),
    .freq_enable(freq_enable),
    .difficulty(difficulty),
    .leds(leds),
    .score(score),
    .misses(misses),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_leds"}, 32'(leds), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_misses"}, 32'(misses), 0);
    check({tag, "_difficulty"}, 32'(difficulty), 0);
    check({tag, "_freq_enable"}, 32'(freq_enable), 0);
    check({tag, "_game_over"}, 32'(game_over), 0);
    check({tag, "_hit_pulse"}, 32'(hit_pulse), 0);
    check({tag, "_miss_pulse"}, 32'(miss_pulse), 0);
  endtask

  // Tick from WAIT_TICK: a fresh one-hot target that differs from the last one.
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("tick_onehot", 32'($countones(leds)), 1);
    check("tick_new_target", 32'(leds != prev_led), 1);
    check("tick_freq_enable", 32'(freq_enable), 1);
    prev_led = leds;
    lit = leds;
  endtask

  task automatic do_hit();
    do_tick();
    buttons = lit;
    step();
    check("hit_pulse", 32'(hit_pulse), 1);
    buttons = 8'd0;
    step();
  endtask

  task automatic do_miss();
    do_tick();
    repeat (20) step();
    check("miss_pulse", 32'(miss_pulse), 1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tick     = 1'b0;
    buttons  = 8'd0;
    prev_led = 8'h01;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    tick = 1'b1;
    step();
    tick = 1'b0;
    check("idle_tick_leds", 32'(leds), 0);
    check("idle_tick_freq", 32'(freq_enable), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_freq", 32'(freq_enable), 1);
    check("start_leds", 32'(leds), 0);

    // First game: press the lit bit in the fifth LIT cycle.
    do_tick();
    repeat (4) step();
    buttons = lit;
    step();
    check("first_hit_pulse", 32'(hit_pulse), 1);
    check("first_hit_score", 32'(score), 1);
    check("first_hit_leds", 32'(leds), 0);
    buttons = 8'd0;
    step();
    check("first_hit_pulse_end", 32'(hit_pulse), 0);

    // Wrong bits ignored, then correct+wrong together counts as a hit.
    do_tick();
    buttons = ~lit;
    step();
    check("wrong_leds", 32'(leds), 32'(lit));
    check("wrong_hit", 32'(hit_pulse), 0);
    check("wrong_miss", 32'(miss_pulse), 0);
    buttons = 8'd0;
    step();
    buttons = 8'hFF;
    step();
    check("mixed_hit", 32'(hit_pulse), 1);
    check("mixed_score", 32'(score), 2);
    buttons = 8'd0;
    step();

    // Press lands in the cycle the counter reaches zero.
    do_tick();
    repeat (19) step();
    check("edge_leds_still_lit", 32'(leds), 32'(lit));
    check("edge_no_miss_yet", 32'(miss_pulse), 0);
    buttons = lit;
    step();
    check("edge_hit", 32'(hit_pulse), 1);
    check("edge_no_miss", 32'(miss_pulse), 0);
    check("edge_misses", 32'(misses), 0);
    check("edge_score", 32'(score), 3);
    buttons = 8'd0;
    step();

    do_tick();
    repeat (19) step();
    check("miss1_early", 32'(miss_pulse), 0);
    step();
    check("miss1_pulse", 32'(miss_pulse), 1);
    check("miss1_count", 32'(misses), 1);
    check("miss1_leds", 32'(leds), 0);
    check("miss1_freq", 32'(freq_enable), 1);
    step();
    check("miss1_pulse_end", 32'(miss_pulse), 0);

    do_miss();
    check("miss2_count", 32'(misses), 2);
    check("miss2_not_over", 32'(game_over), 0);
    do_miss();
    check("miss3_count", 32'(misses), 3);
    check("miss3_game_over", 32'(game_over), 1);
    check("miss3_freq", 32'(freq_enable), 0);
    check("miss3_leds", 32'(leds), 0);

    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("over_tick_leds", 32'(leds), 0);
    check("over_score_held", 32'(score), 3);
    check("over_misses_held", 32'(misses), 3);
    check("over_still", 32'(game_over), 1);

    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_score", 32'(score), 0);
    check("restart_misses", 32'(misses), 0);
    check("restart_game_over", 32'(game_over), 0);
    check("restart_freq", 32'(freq_enable), 1);

    for (int i = 1; i <= 36; i++) begin
      do_hit();
      if (i == 3)  check("diff_after_3", 32'(difficulty), 0);
      if (i == 4)  check("diff_after_4", 32'(difficulty), 1);
      if (i == 8)  check("diff_after_8", 32'(difficulty), 2);
      if (i == 28) check("diff_after_28", 32'(difficulty), 7);
      if (i == 32) check("diff_after_32", 32'(difficulty), 7);
      if (i == 36) check("diff_after_36", 32'(difficulty), 7);
    end
    check("score_36", 32'(score), 36);

    // Button held across the tick needs a release and re-press.
    buttons = 8'hFF;
    step();
    do_tick();
    step();
    step();
    check("held_no_hit", 32'(hit_pulse), 0);
    check("held_leds", 32'(leds), 32'(lit));
    buttons = 8'd0;
    step();
    check("release_no_hit", 32'(hit_pulse), 0);
    buttons = lit;
    step();
    check("repress_hit", 32'(hit_pulse), 1);
    check("repress_score", 32'(score), 37);
    buttons = 8'd0;
    step();

    for (int i = 0; i < 218; i++) do_hit();
    check("score_255", 32'(score), 255);
    do_hit();
    do_hit();
    check("score_sat", 32'(score), 255);

    // Reset while a target is lit.
    do_tick();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_mid_lit");
    prev_led = 8'h01;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("post_rst_tick_leds", 32'(leds), 0);
    check("post_rst_tick_freq", 32'(freq_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
